// File: rtl/life_manager.sv
// life_manager: per-player lives and respawn timing for Mario and Luigi, plus the global game-over flag.
// Latency: a hit or bonus on cycle N is visible on N+1; a respawn pulse follows the last of RESPAWN_FRAMES frame ticks by one Clk.
// Backpressure: none; every input is a pulse or level that is consumed when it arrives and never stalls.
//
// Ports:
//   Clk, Reset           system clock, synchronous active-high reset
//   frame_clk            vsync-derived frame signal, synchronous to Clk (rising edge = one frame tick)
//   mario_hit/luigi_hit  one-Clk lethal-hit pulses
//   restart              level; starts a new game once the game-over hold has expired
//   *_life_counter       2-bit lives remaining
//   *_alive              player is controllable and drawn
//   *_respawn            one-Clk pulse, reposition the player
//   game_over            both players are out of lives
// Optional feature macro LIFE_BONUS_EN adds mario_bonus/luigi_bonus 1-up pulse inputs.

module life_player #(
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       hit,
    input  logic       bonus,
    input  logic       revive,
    output logic [1:0] count,
    output logic       alive,
    output logic       respawn,
    output logic       out_next
);
    localparam logic [1:0] ST_ALIVE = 2'd0;
    localparam logic [1:0] ST_DEAD  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [1:0] START_CNT = START_LIVES[1:0];
    localparam logic [7:0] RESP_LOAD = RESPAWN_FRAMES[7:0];

    logic [1:0] state;
    logic [1:0] state_d;
    logic [1:0] count_d;
    logic [7:0] timer;
    logic [7:0] timer_d;
    logic       respawn_d;

    always_comb begin
        state_d   = state;
        count_d   = count;
        timer_d   = timer;
        respawn_d = 1'b0;
        if (revive) begin
            state_d   = ST_ALIVE;
            count_d   = START_CNT;
            timer_d   = 8'd0;
            respawn_d = 1'b1;
        end else begin
            case (state)
                ST_ALIVE: begin
                    // A hit outranks a simultaneous bonus; the bonus is simply dropped.
                    if (hit) begin
                        if (count <= 2'd1) begin
                            count_d = 2'd0;
                            state_d = ST_OUT;
                        end else begin
                            count_d = count - 2'd1;
                            state_d = ST_DEAD;
                            timer_d = RESP_LOAD;
                        end
                    end else if (bonus && (count != 2'd3)) begin
                        count_d = count + 2'd1;
                    end
                end
                ST_DEAD: begin
                    // The timer only counts in DEAD, so a tick coinciding with the
                    // killing hit never eats into the freshly loaded value.
                    if (tick) begin
                        if (timer <= 8'd1) begin
                            state_d   = ST_ALIVE;
                            timer_d   = 8'd0;
                            respawn_d = 1'b1;
                        end else begin
                            timer_d = timer - 8'd1;
                        end
                    end
                end
                ST_OUT: begin
                    state_d = ST_OUT;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    // Lets the global FSM enter game-over on the same edge as the final hit.
    assign out_next = (state_d == ST_OUT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_ALIVE;
            count   <= START_CNT;
            timer   <= 8'd0;
            alive   <= 1'b1;
            respawn <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            timer   <= timer_d;
            alive   <= (state_d == ST_ALIVE);
            respawn <= respawn_d;
        end
    end
endmodule

module life_manager #(
    parameter int START_LIVES          = 3,
    parameter int RESPAWN_FRAMES       = 120,
    parameter int GAMEOVER_HOLD_FRAMES = 180
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       mario_hit,
    input  logic       luigi_hit,
`ifdef LIFE_BONUS_EN
    input  logic       mario_bonus,
    input  logic       luigi_bonus,
`endif
    input  logic       restart,
    output logic [1:0] mario_life_counter,
    output logic [1:0] luigi_life_counter,
    output logic       mario_alive,
    output logic       luigi_alive,
    output logic       mario_respawn,
    output logic       luigi_respawn,
    output logic       game_over
);
    localparam logic [0:0] G_PLAY = 1'b0;
    localparam logic [0:0] G_OVER = 1'b1;

    localparam logic [7:0] HOLD_LOAD = GAMEOVER_HOLD_FRAMES[7:0];

    logic       frame_q;
    logic       tick;
    logic [0:0] g_state;
    logic [0:0] g_state_d;
    logic [7:0] hold;
    logic [7:0] hold_d;
    logic       revive;
    logic       m_out_next;
    logic       l_out_next;
    logic       m_bonus;
    logic       l_bonus;

`ifdef LIFE_BONUS_EN
    assign m_bonus = mario_bonus;
    assign l_bonus = luigi_bonus;
`else
    assign m_bonus = 1'b0;
    assign l_bonus = 1'b0;
`endif

    // Registered edge detect: the tick is high for one Clk, one Clk after frame_clk rises.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            frame_q <= frame_clk;
            tick    <= frame_clk & ~frame_q;
        end
    end

    // Kept apart from the FSM next-state block: players read revive and the
    // FSM reads their out_next, so sharing one block would form a false loop.
    assign revive = (g_state == G_OVER) && (hold == 8'd0) && restart;

    always_comb begin
        g_state_d = g_state;
        hold_d    = hold;
        case (g_state)
            G_PLAY: begin
                if (m_out_next && l_out_next) begin
                    g_state_d = G_OVER;
                    hold_d    = HOLD_LOAD;
                end
            end
            G_OVER: begin
                if (revive) begin
                    g_state_d = G_PLAY;
                end else if (tick && (hold != 8'd0)) begin
                    hold_d = hold - 8'd1;
                end
            end
            default: begin
                g_state_d = G_PLAY;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            g_state   <= G_PLAY;
            hold      <= 8'd0;
            game_over <= 1'b0;
        end else begin
            g_state   <= g_state_d;
            hold      <= hold_d;
            game_over <= (g_state_d == G_OVER);
        end
    end

    life_player #(
        .START_LIVES    (START_LIVES),
        .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) u_mario (
        .Clk      (Clk),
        .Reset    (Reset),
        .tick     (tick),
        .hit      (mario_hit),
        .bonus    (m_bonus),
        .revive   (revive),
        .count    (mario_life_counter),
        .alive    (mario_alive),
        .respawn  (mario_respawn),
        .out_next (m_out_next)
    );

    life_player #(
        .START_LIVES    (START_LIVES),
        .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) u_luigi (
        .Clk      (Clk),
        .Reset    (Reset),
        .tick     (tick),
        .hit      (luigi_hit),
        .bonus    (l_bonus),
        .revive   (revive),
        .count    (luigi_life_counter),
        .alive    (luigi_alive),
        .respawn  (luigi_respawn),
        .out_next (l_out_next)
    );
endmodule
